// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Request/response sequencer in front of the 4-bit calculator ALU.
//   It accepts one operation at a time and rejects unknown opcodes and
//   division by zero without touching the ALU. Valid operations are issued
//   to the ALU for exactly as long as the ALU needs them. The result is
//   captured and normalised, then held on a valid/ready response channel.
//
// Ports
//   clk, rst        clock and synchronous active-high reset (shared with ALU)
//   req_valid/ready request handshake; ready only while idle
//   req_op          1000 add, 0100 sub, 0010 mul, 0001 div, others invalid
//   req_sign        signed operation
//   req_a, req_b    operands (a op b)
//   resp_valid/ready response handshake; response held until accepted
//   resp_result     normalised 8-bit result
//   resp_err        invalid op, divide by zero or timeout
//   busy            high whenever a request is in flight
//   alu_op          opcode to ALU, 0000 = STOP
//   alu_sign        sign mode to ALU
//   alu_data1/2     operands to ALU
//   alu_o           ALU result
//   alu_busy        ALU iterating (mul/div)
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic       req_sign,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_result,
    output logic       resp_err,
    output logic       busy,
    output logic [3:0] alu_op,
    output logic       alu_sign,
    output logic [3:0] alu_data1,
    output logic [3:0] alu_data2,
    input  logic [7:0] alu_o,
    input  logic       alu_busy
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_STOP = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CAPT      = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       op_r;
    logic             sign_r;
    logic [3:0]       a_r;
    logic [3:0]       b_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       result_r;
    logic             err_r;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic             busy_r;
    logic [3:0]       alu_op_s;
    logic             timeout_s;
    logic             req_bad_s;

    function automatic logic op_is_valid(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: op_is_valid = 1'b1;
            default:                        op_is_valid = 1'b0;
        endcase
    endfunction

    // mul and div run for several cycles inside the ALU and report via alu_busy
    function automatic logic op_is_iterative(input logic [3:0] op);
        op_is_iterative = (op == OP_MUL) || (op == OP_DIV);
    endfunction

    assign req_bad_s = !op_is_valid(req_op) || ((req_op == OP_DIV) && (req_b == 4'd0));
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT));

    // Next-state decode and ALU opcode; alu_op drops to STOP combinationally
    // from alu_busy so the ALU never sees a restart on its completion edge.
    always_comb begin
        state_next_s = state_r;
        alu_op_s     = OP_STOP;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad_s) begin
                        state_next_s = ST_RESP;
                    end else begin
                        state_next_s = ST_EXEC;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (timeout_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    alu_op_s = op_r;
                    if (op_is_iterative(op_r)) begin
                        state_next_s = ST_WAIT_DONE;
                    end else begin
                        state_next_s = ST_CAPT;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (timeout_s) begin
                    state_next_s = ST_RESP;
                end else if (alu_busy) begin
                    alu_op_s     = op_r;
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_CAPT: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            req_ready_r  <= (state_next_s == ST_IDLE);
            resp_valid_r <= (state_next_s == ST_RESP);
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    // Request latch, cycle counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= OP_STOP;
            sign_r   <= 1'b0;
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            cnt_r    <= '0;
            result_r <= 8'd0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r     <= req_op;
                        sign_r   <= req_sign;
                        a_r      <= req_a;
                        b_r      <= req_b;
                        cnt_r    <= '0;
                        result_r <= 8'd0;
                        err_r    <= req_bad_s;
                    end
                end
                ST_EXEC: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (timeout_s) begin
                        result_r <= 8'd0;
                        err_r    <= 1'b1;
                    end
                end
                ST_CAPT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (timeout_s) begin
                        result_r <= 8'd0;
                        err_r    <= 1'b1;
                    end else begin
                        // add/sub only drive the low five bits; the rest is stale
                        result_r <= {3'b000, alu_o[4:0]};
                        err_r    <= 1'b0;
                    end
                end
                ST_WAIT_DONE: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (timeout_s) begin
                        result_r <= 8'd0;
                        err_r    <= 1'b1;
                    end else if (!alu_busy) begin
                        result_r <= alu_o;
                        err_r    <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        op_r     <= OP_STOP;
                        sign_r   <= 1'b0;
                        a_r      <= 4'd0;
                        b_r      <= 4'd0;
                        result_r <= 8'd0;
                        err_r    <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign busy        = busy_r;
    assign resp_result = result_r;
    assign resp_err    = err_r;
    assign alu_op      = alu_op_s;
    assign alu_sign    = sign_r;
    assign alu_data1   = a_r;
    assign alu_data2   = b_r;

endmodule
